crack_ctrl: RTL and testbench

- Key-search sequencer for the ARC4 brute-force cracker.
- Walks a candidate key space (start, step) and launches the arc4 decrypt engine once per candidate.
- Snoops the engine's plaintext-memory writes and stops on the first key whose decrypted message is all printable ASCII.
- Sits between the cracker top (task4/task5) and one arc4 instance; STEP>1 lets two instances split the key space.

---
 rtl/arc4_pkg.sv | 19 +
 rtl/pt_checker.sv | 35 +++
 rtl/crack_ctrl.sv | 134 +++++++++++++
 tb/tb_crack_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 key-search sequencer.
package arc4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    BUSY,
    RUN,
    EVAL
  } crack_state_t;

  localparam logic [7:0] ASCII_MIN = 8'h20;
  localparam logic [7:0] ASCII_MAX = 8'h7E;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_MIN) && (b <= ASCII_MAX);
  endfunction

endpackage

// File: rtl/pt_checker.sv
// Plaintext snooper: captures the message length written at address 0 and
// raises a sticky flag when any byte inside the message is not printable.
// Bytes beyond the recorded length are padding and do not count.
import arc4_pkg::*;

module pt_checker (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       snoop_en,
  input  logic [7:0] pt_addr,
  input  logic [7:0] pt_wrdata,
  input  logic       pt_wren,
  output logic       bad,
  output logic [7:0] msg_len
);

  // Length capture and sticky bad flag, cleared at the start of each candidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad     <= 1'b0;
      msg_len <= 8'd0;
    end else if (clear) begin
      bad     <= 1'b0;
      msg_len <= 8'd0;
    end else if (snoop_en && pt_wren) begin
      if (pt_addr == 8'd0) begin
        msg_len <= pt_wrdata;
      end else if ((pt_addr <= msg_len) && !is_printable(pt_wrdata)) begin
        bad <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/crack_ctrl.sv
// Key-search sequencer: steps through candidate keys, launches one arc4
// decrypt per key and stops on the first key whose plaintext is printable.
//
// state  | meaning
// IDLE   | ready for en; done/key_valid/key hold the last result
// LAUNCH | waiting for arc4_rdy, then pulse arc4_en
// BUSY   | waiting for the engine to drop rdy (start accepted)
// RUN    | engine decrypting; plaintext writes are snooped
// EVAL   | decide: found, exhausted, or advance to the next key
import arc4_pkg::*;

module crack_ctrl #(
  parameter int                   KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
  parameter int unsigned          KEY_STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 rdy,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 key_valid,
  output logic                 done,
  output logic                 arc4_en,
  input  logic                 arc4_rdy,
  input  logic [7:0]           pt_addr,
  input  logic [7:0]           pt_wrdata,
  input  logic                 pt_wren
);

  // One extra bit so a step past the top of the key space shows up as carry.
  localparam logic [KEY_WIDTH:0] STEP_EXT = (KEY_WIDTH+1)'(KEY_STEP);

  crack_state_t     state, state_next;
  logic [KEY_WIDTH:0] key_next;
  logic             bad;
  logic [7:0]       msg_len;
  logic             chk_clear;
  logic             snoop_en;
  logic             start;
  logic             found;
  logic             exhausted;
  logic             advance;

  assign key_next = {1'b0, key} + STEP_EXT;
  assign rdy      = (state == IDLE);
  assign snoop_en = (state == BUSY) || (state == RUN);

  pt_checker u_pt_checker (
    .clk       (clk),
    .rst       (rst),
    .clear     (chk_clear),
    .snoop_en  (snoop_en),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren),
    .bad       (bad),
    .msg_len   (msg_len)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and control decode.
  always_comb begin
    state_next = state;
    arc4_en    = 1'b0;
    chk_clear  = 1'b0;
    start      = 1'b0;
    found      = 1'b0;
    exhausted  = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          start      = 1'b1;
          chk_clear  = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        if (arc4_rdy) begin
          arc4_en    = 1'b1;
          chk_clear  = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (!arc4_rdy) state_next = RUN;
      end
      RUN: begin
        if (arc4_rdy) state_next = EVAL;
      end
      EVAL: begin
        if (!bad) begin
          found      = 1'b1;
          state_next = IDLE;
        end else if (key_next[KEY_WIDTH]) begin
          exhausted  = 1'b1;
          state_next = IDLE;
        end else begin
          advance    = 1'b1;
          state_next = LAUNCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Candidate key and result flags; results hold until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key       <= KEY_START;
      key_valid <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      key       <= KEY_START;
      key_valid <= 1'b0;
      done      <= 1'b0;
    end else if (found) begin
      key_valid <= 1'b1;
      done      <= 1'b1;
    end else if (exhausted) begin
      key_valid <= 1'b0;
      done      <= 1'b1;
    end else if (advance) begin
      key <= key_next[KEY_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_crack_ctrl.sv
// Bench for crack_ctrl: a behavioural arc4 stub replays per-key plaintext
// tables; the expected result is the first key whose table entry is printable.
module tb_crack_ctrl;

  logic clk;
  logic rst;
  logic en1, en2, hold_low;

  logic        rdy1, kv1, done1, a_en1, r1;
  logic [23:0] key1;
  logic        rdy2, kv2, done2, a_en2, r2;
  logic [3:0]  key2;

  logic       s_rdy  [2];
  logic       s_busy [2];
  logic       s_wren [2];
  logic [7:0] s_addr [2];
  logic [7:0] s_data [2];
  logic [3:0] s_key  [2];
  int         s_cnt  [2];

  logic [7:0] tab [16][256];
  int         wcnt [16];

  int tests, fails;
  int n_launch;
  int exp_key;
  logic exp_kv;
  int q2 [$];

  assign r1 = s_rdy[0] && !hold_low;
  assign r2 = s_rdy[1];

  crack_ctrl #(.KEY_WIDTH(24), .KEY_START(24'd0), .KEY_STEP(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .rdy(rdy1), .key(key1),
    .key_valid(kv1), .done(done1), .arc4_en(a_en1), .arc4_rdy(r1),
    .pt_addr(s_addr[0]), .pt_wrdata(s_data[0]), .pt_wren(s_wren[0])
  );

  crack_ctrl #(.KEY_WIDTH(4), .KEY_START(4'd1), .KEY_STEP(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .rdy(rdy2), .key(key2),
    .key_valid(kv2), .done(done2), .arc4_en(a_en2), .arc4_rdy(r2),
    .pt_addr(s_addr[1]), .pt_wrdata(s_data[1]), .pt_wren(s_wren[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int stub_wcnt(int g, logic [3:0] k);
    return (g == 0) ? wcnt[k] : 2;
  endfunction

  function automatic logic [7:0] stub_byte(int g, logic [3:0] k, int i);
    if (g == 0) return tab[k][i];
    return (i == 0) ? 8'd1 : 8'd0;
  endfunction

  // Stub engine: rdy drops the cycle after en, then one write per cycle
  // (length at address 0 first), rdy rises after at least 20 cycles.
  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        s_busy[g] <= 1'b0; s_rdy[g] <= 1'b1; s_wren[g] <= 1'b0;
        s_addr[g] <= 8'd0; s_data[g] <= 8'd0; s_cnt[g] <= 0; s_key[g] <= 4'd0;
      end else if (!s_busy[g]) begin
        s_wren[g] <= 1'b0;
        if ((g == 0) ? a_en1 : a_en2) begin
          s_busy[g] <= 1'b1;
          s_rdy[g]  <= 1'b0;
          s_cnt[g]  <= 0;
          s_key[g]  <= (g == 0) ? key1[3:0] : key2;
        end
      end else begin
        s_cnt[g] <= s_cnt[g] + 1;
        if (s_cnt[g] < stub_wcnt(g, s_key[g])) begin
          s_wren[g] <= 1'b1;
          s_addr[g] <= 8'(s_cnt[g]);
          s_data[g] <= stub_byte(g, s_key[g], s_cnt[g]);
        end else begin
          s_wren[g] <= 1'b0;
        end
        if (s_cnt[g] >= ((stub_wcnt(g, s_key[g]) + 1 > 20) ? stub_wcnt(g, s_key[g]) + 1 : 20)) begin
          s_rdy[g]  <= 1'b1;
          s_busy[g] <= 1'b0;
          s_wren[g] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: first key in table order whose message bytes 1..len are all printable.
  function automatic int first_valid();
    for (int k = 0; k < 16; k++) begin
      bit ok;
      int len;
      ok  = 1'b1;
      len = int'(tab[k][0]);
      for (int i = 1; i <= len && i < wcnt[k]; i++)
        if (tab[k][i] < 8'h20 || tab[k][i] > 8'h7E) ok = 1'b0;
      if (ok) return k;
    end
    return -1;
  endfunction

  task automatic set_msg(input int k, input int len, input int wc);
    tab[k][0] = 8'(len);
    for (int i = 1; i < 256; i++)
      tab[k][i] = (i <= len) ? 8'($urandom_range(32, 126)) : 8'($urandom_range(0, 255));
    wcnt[k] = wc;
  endtask

  task automatic clear_tab();
    for (int k = 0; k < 16; k++) begin
      set_msg(k, 1, 2);
      tab[k][1] = 8'h00;
    end
  endtask

  function automatic logic [7:0] bad_byte();
    return ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(127, 255));
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start1();
    exp_key = first_valid();
    exp_kv  = (exp_key >= 0);
    chk("start_rdy", 32'(rdy1), 32'd1);
    en1 = 1'b1;
    tick(1);
    en1 = 1'b0;
  endtask

  task automatic wait_done1(input string nm, input int budget);
    int c;
    c = 0;
    while (!(done1 && rdy1) && c < budget) begin
      tick(1);
      c++;
    end
    chk({nm, "_done"}, 32'(done1 && rdy1), 32'd1);
    tick(1);
  endtask

  task automatic check_result(input string nm, input int k, input int launches);
    chk({nm, "_key"}, 32'(key1), 32'(k));
    chk({nm, "_kv"}, 32'(kv1), 32'd1);
    chk({nm, "_launches"}, 32'(n_launch), 32'(launches));
  endtask

  // Per-cycle compare for dut1: each launch must carry the next candidate and
  // see arc4_rdy high; each completion must match the table-derived result.
  task automatic mon1();
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_launch = 0;
      end else begin
        if (rdy1 && en1) n_launch = 0;
        if (a_en1) begin
          chk("launch_rdy", 32'(r1), 32'd1);
          chk("launch_key", 32'(key1), 32'(n_launch));
          n_launch++;
        end
        if (done1 && !prev_done) begin
          chk("done_kv", 32'(kv1), 32'(exp_kv));
          if (exp_kv) begin
            chk("done_key", 32'(key1), 32'(exp_key));
            chk("done_launches", 32'(n_launch), 32'(exp_key + 1));
          end
        end
      end
      prev_done = done1;
    end
  endtask

  task automatic mon2();
    forever begin
      @(negedge clk);
      if (rst || (rdy2 && en2)) q2.delete();
      else if (a_en2) q2.push_back(int'(key2));
    end
  endtask

  initial begin
    int c, tgt, len;
    tests = 0; fails = 0; n_launch = 0; exp_key = 0; exp_kv = 1'b0;
    rst = 1'b1; en1 = 1'b0; en2 = 1'b0; hold_low = 1'b0;
    clear_tab();
    fork
      mon1();
      mon2();
    join_none
    tick(3);
    chk("rst_rdy", 32'(rdy1), 32'd1);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_kv", 32'(kv1), 32'd0);
    chk("rst_arc4_en", 32'(a_en1), 32'd0);
    chk("rst_key", 32'(key1), 32'd0);
    chk("rst_key2", 32'(key2), 32'd1);
    rst = 1'b0;
    tick(2);

    // Found on key 3.
    clear_tab();
    set_msg(3, 4, 5);
    chk("pin_found", 32'(first_valid()), 32'd3);
    start1();
    wait_done1("found", 2000);
    check_result("found", 3, 4);
    tick(5);
    chk("found_hold_done", 32'(done1), 32'd1);
    chk("found_hold_key", 32'(key1), 32'd3);

    // en held high for 50 cycles: one search only.
    exp_key = first_valid(); exp_kv = 1'b1;
    en1 = 1'b1;
    tick(50);
    en1 = 1'b0;
    wait_done1("en_held", 2000);
    check_result("en_held", 3, 4);

    // en pulsed while busy is ignored.
    start1();
    tick(30);
    chk("busy_rdy", 32'(rdy1), 32'd0);
    en1 = 1'b1;
    tick(1);
    en1 = 1'b0;
    wait_done1("en_busy", 2000);
    check_result("en_busy", 3, 4);

    // Engine not ready in LAUNCH: no pulse until it is.
    hold_low = 1'b1;
    start1();
    tick(10);
    chk("hold_no_launch", 32'(n_launch), 32'd0);
    chk("hold_arc4_en", 32'(a_en1), 32'd0);
    hold_low = 1'b0;
    wait_done1("hold", 2000);
    check_result("hold", 3, 4);

    // Length boundary: last byte inside is 7E, byte past the end is 00.
    clear_tab();
    set_msg(0, 5, 7);
    tab[0][5] = 8'h7E;
    tab[0][6] = 8'h00;
    chk("pin_len_ok", 32'(first_valid()), 32'd0);
    start1();
    wait_done1("len_ok", 2000);
    check_result("len_ok", 0, 1);

    // Same but the last byte inside is 1F: key 0 rejected, key 1 valid.
    tab[0][5] = 8'h1F;
    set_msg(1, 2, 3);
    chk("pin_len_bad", 32'(first_valid()), 32'd1);
    start1();
    wait_done1("len_bad", 2000);
    check_result("len_bad", 1, 2);

    // Empty message with garbage written everywhere past it.
    clear_tab();
    set_msg(0, 0, 256);
    tab[0][1] = 8'h00;
    chk("pin_empty", 32'(first_valid()), 32'd0);
    start1();
    wait_done1("empty", 4000);
    check_result("empty", 0, 1);

    // Randomized key tables.
    for (int t = 0; t < 6; t++) begin
      tgt = $urandom_range(0, 7);
      for (int k = 0; k < 16; k++) begin
        len = $urandom_range(0, 12);
        if (k < tgt && len == 0) len = 1;
        set_msg(k, len, len + 1 + $urandom_range(0, 3));
        if (len > 0 && (k < tgt || (k > tgt && $urandom_range(0, 1) == 1)))
          tab[k][$urandom_range(1, len)] = bad_byte();
      end
      start1();
      wait_done1("rand", 4000);
      chk("rand_key", 32'(key1), 32'(exp_key));
      chk("rand_launches", 32'(n_launch), 32'(exp_key + 1));
    end

    // Reset in the middle of RUN on the third candidate.
    clear_tab();
    set_msg(3, 4, 5);
    start1();
    c = 0;
    while (n_launch < 3 && c < 500) begin
      tick(1);
      c++;
    end
    chk("pre_rst_launches", 32'(n_launch), 32'd3);
    tick(5);
    chk("pre_rst_busy", 32'(rdy1), 32'd0);
    chk("pre_rst_key", 32'(key1), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(rdy1), 32'd1);
    chk("mid_rst_done", 32'(done1), 32'd0);
    chk("mid_rst_kv", 32'(kv1), 32'd0);
    chk("mid_rst_arc4_en", 32'(a_en1), 32'd0);
    chk("mid_rst_key", 32'(key1), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // Exhaustion on the 4-bit, step-2 instance.
    en2 = 1'b1;
    tick(1);
    en2 = 1'b0;
    c = 0;
    while (!(done2 && rdy2) && c < 1000) begin
      tick(1);
      c++;
    end
    chk("exh_done", 32'(done2 && rdy2), 32'd1);
    tick(1);
    chk("exh_launches", 32'(q2.size()), 32'd8);
    for (int i = 0; i < 8 && i < q2.size(); i++)
      chk("exh_seq_key", 32'(q2[i]), 32'(1 + 2 * i));
    chk("exh_kv", 32'(kv2), 32'd0);
    chk("exh_key", 32'(key2), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
